// File: rtl/serializer_sched.sv
// Round-robin scheduler that shares one serializer between NREQ requesters.
// Optional WAIT watchdog is enabled with `define SCHED_TIMEOUT_EN.
module serializer_sched #(
  parameter int NREQ        = 4,
  parameter int DW          = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*DW-1:0] data_i,
  output logic [NREQ-1:0]    ack_o,
  output logic               busy_o,
  output logic               ser_start_o,
  output logic [DW-1:0]      ser_data_o,
  input  logic               ser_done_i,
  output logic               err_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_ACK
  } state_e;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("serializer_sched: parameter out of range");
  end

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            start_q, start_d;
  logic            busy_q, busy_d;

`ifdef SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  logic [DW-1:0]   words [NREQ];
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;

  // Scan ptr+1, ptr+2, ... modulo NREQ; iterating from the far end keeps the nearest hit.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] req,
                                          input logic [IW-1:0]   ptr);
    logic [IW:0]   res;
    logic [IW-1:0] sel;
    int            idx;
    res = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      sel = IW'(idx);
      if (req[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  always_comb begin
    for (int k = 0; k < NREQ; k++) words[k] = data_i[k*DW +: DW];
    {pick_vld, pick_idx} = rr_pick(req_i, ptr_q);
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
`ifdef SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_idx;
          data_d  = words[pick_idx];
          state_d = S_START;
        end
      end
      S_START: begin
        // A done strobe here belongs to nothing we launched; it is ignored.
        state_d = S_WAIT;
`ifdef SCHED_TIMEOUT_EN
        cnt_d   = CW'(TIMEOUT_CYC - 1);
`endif
      end
      S_WAIT: begin
        if (ser_done_i) begin
          state_d = S_ACK;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (cnt_q == '0) begin
          state_d = S_ACK;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      S_ACK: begin
        ptr_d   = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    start_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE);
    ack_d   = (state_d == S_ACK) ? (NREQ'(1) << gnt_d) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(NREQ - 1);
      gnt_q   <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      busy_q  <= busy_d;
`ifdef SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign ack_o       = ack_q;
  assign busy_o      = busy_q;
  assign ser_start_o = start_q;
  assign ser_data_o  = data_q;
`ifdef SCHED_TIMEOUT_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_serializer_sched.sv
// Directed bench for serializer_sched: expected grant/word pairs are queued when a
// request is driven and popped when the matching ack appears.
module tb_serializer_sched;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TO   = 16;
`ifdef SCHED_TIMEOUT_EN
  localparam int DONE_DLY = 14;
`else
  localparam int DONE_DLY = 20;
`endif

  typedef struct {
    logic [NREQ-1:0] ack;
    logic [DW-1:0]   data;
  } exp_t;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [NREQ-1:0]    req_i;
  logic [NREQ*DW-1:0] data_i;
  logic [NREQ-1:0]    ack_o;
  logic               busy_o;
  logic               ser_start_o;
  logic [DW-1:0]      ser_data_o;
  logic               ser_done_i;
  logic               err_o;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  serializer_sched #(
    .NREQ       (NREQ),
    .DW         (DW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .data_i     (data_i),
    .ack_o      (ack_o),
    .busy_o     (busy_o),
    .ser_start_o(ser_start_o),
    .ser_data_o (ser_data_o),
    .ser_done_i (ser_done_i),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One full transfer: drive req, expect start on the next cycle, strobe done
  // dly cycles after start, expect ack one cycle later, then an idle cycle.
  task automatic xfer(input logic [NREQ-1:0] req, input int win, input int dly,
                      input logic [NREQ-1:0] req_after, input bit done_in_start);
    exp_t e;
    int   extra_start;
    int   bad;
    e.ack  = NREQ'(1) << win;
    e.data = data_i[win*DW +: DW];
    sb_q.push_back(e);
    req_i = req;
    tick();
    check($sformatf("start_w%0d", win), ser_start_o, 1);
    check($sformatf("busy_w%0d", win), busy_o, 1);
    check($sformatf("ser_data_w%0d", win), ser_data_o, sb_q[0].data);
    if (done_in_start) ser_done_i = 1'b1;
    extra_start = 0;
    bad         = 0;
    for (int k = 1; k <= dly; k++) begin
      tick();
      ser_done_i = 1'b0;
      if (ser_start_o) extra_start++;
      if (ack_o !== '0 || !busy_o) bad++;
      if (k == dly) ser_done_i = 1'b1;
    end
    tick();
    ser_done_i = 1'b0;
    e = sb_q.pop_front();
    check($sformatf("ack_w%0d", win), ack_o, e.ack);
    check($sformatf("err_w%0d", win), err_o, 0);
    check($sformatf("data_held_w%0d", win), ser_data_o, e.data);
    check($sformatf("wait_quiet_w%0d", win), bad, 0);
    check($sformatf("one_start_w%0d", win), extra_start, 0);
    req_i = req_after;
    tick();
    check($sformatf("idle_ack_w%0d", win), ack_o, 0);
    check($sformatf("idle_busy_w%0d", win), busy_o, 0);
    check($sformatf("idle_start_w%0d", win), ser_start_o, 0);
  endtask

  initial begin
    int rot [6] = '{0, 1, 2, 3, 0, 1};
    int busy_drop;
    int err_seen;
    int acks;

    rst_i      = 1'b0;
    req_i      = '0;
    ser_done_i = 1'b0;
    data_i     = {8'hD3, 8'hA5, 8'h7E, 8'h31};

    tick();
    tick();
    check("rst_ack", ack_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_start", ser_start_o, 0);
    check("rst_data", ser_data_o, 0);
    check("rst_err", err_o, 0);
    rst_i = 1'b1;
    tick();

    // Launch a transfer for requester 1, then reset while it sits in WAIT.
    req_i = 4'b0010;
    tick();
    check("pre_rst_start", ser_start_o, 1);
    check("pre_rst_data", ser_data_o, 8'h7E);
    tick();
    tick();
    check("pre_rst_busy", busy_o, 1);
    rst_i = 1'b0;
    req_i = 4'b0001;
    #1;
    check("midrst_ack", ack_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_start", ser_start_o, 0);
    check("midrst_data", ser_data_o, 0);
    check("midrst_err", err_o, 0);
    tick();
    rst_i = 1'b1;
    // First scan after reset starts at index 0.
    xfer(4'b0001, 0, 5, 4'b0000, 1'b0);

    xfer(4'b0100, 2, DONE_DLY, 4'b0000, 1'b0);
    xfer(4'b1000, 3, 3, 4'b1111, 1'b0);

    for (int i = 0; i < 6; i++)
      xfer(4'b1111, rot[i], 2 + i, (i == 5) ? 4'b0000 : 4'b1111, 1'b0);

    // Wrap-around: after grant 3, requesters 0 and 3 are served 0 then 3.
    xfer(4'b1000, 3, 2, 4'b0000, 1'b0);
    xfer(4'b1001, 0, 4, 4'b1001, 1'b1);
    xfer(4'b1001, 3, 2, 4'b0000, 1'b0);

`ifdef SCHED_TIMEOUT_EN
    // Done arriving in the same cycle the counter expires counts as success.
    xfer(4'b0100, 2, TO, 4'b0000, 1'b0);
    req_i = 4'b0010;
    tick();
    check("to_start", ser_start_o, 1);
    acks = 0;
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (ack_o !== '0 || err_o !== 1'b0) acks++;
    end
    check("to_no_early_ack", acks, 0);
    tick();
    check("to_ack", ack_o, 4'b0010);
    check("to_err", err_o, 1);
    req_i = '0;
    tick();
    check("to_err_clear", err_o, 0);
    check("to_idle_busy", busy_o, 0);
`else
    // Without the watchdog the scheduler waits indefinitely for done.
    req_i = 4'b0010;
    tick();
    check("nto_start", ser_start_o, 1);
    busy_drop = 0;
    err_seen  = 0;
    acks      = 0;
    for (int k = 0; k < 3 * TO; k++) begin
      tick();
      if (busy_o !== 1'b1) busy_drop++;
      if (err_o !== 1'b0) err_seen++;
      if (ack_o !== '0) acks++;
    end
    check("nto_busy_held", busy_drop, 0);
    check("nto_err_zero", err_seen, 0);
    check("nto_no_ack", acks, 0);
    ser_done_i = 1'b1;
    tick();
    ser_done_i = 1'b0;
    check("nto_ack", ack_o, 4'b0010);
    check("nto_ack_err", err_o, 0);
    req_i = '0;
    tick();
    check("nto_idle_busy", busy_o, 0);
`endif

    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
